// File: rtl/axil_win_copy.sv
// axil_win_copy
// AXI4-lite bus master that copies a 2D window of words from a source frame
// to a destination frame. Each frame has its own row pitch. Reads are issued
// ahead into a small read-data FIFO. The number of reads in flight is limited
// by the free FIFO space. The number of writes awaiting a B response is
// limited by MAX_WR_OUT.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m_aw*/m_w*/m_b*       AXI4-lite write address / data / response channels
//   m_ar*/m_r*            AXI4-lite read address / data channels
//   cfg_hsize, cfg_vsize  window size (words per row, rows)
//   cfg_src_baddr/pitch   source window origin and row pitch in bytes
//   cfg_dst_baddr/pitch   destination window origin and row pitch in bytes
//   cfg_start             start pulse, accepted only while idle
//   busy                  copy in progress
//   done                  one-cycle completion pulse
//   err                   sticky bus response error, cleared on start
//   beat_cnt              number of writes acknowledged in the current copy
module axil_win_copy #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DIM_W      = 8,
    parameter int PITCH_W    = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WR_OUT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [2:0]            m_arprot,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_rready,
    input  logic [DIM_W-1:0]      cfg_hsize,
    input  logic [DIM_W-1:0]      cfg_vsize,
    input  logic [ADDR_W-1:0]     cfg_src_baddr,
    input  logic [ADDR_W-1:0]     cfg_dst_baddr,
    input  logic [PITCH_W-1:0]    cfg_src_pitch,
    input  logic [PITCH_W-1:0]    cfg_dst_pitch,
    input  logic                  cfg_start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2*DIM_W-1:0]    beat_cnt
);
    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_SH = $clog2(BYTES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TOT_W  = 2 * DIM_W;
    localparam int WO_W   = $clog2(MAX_WR_OUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg;
    logic                  busy_reg, done_reg, err_reg;
    logic [TOT_W-1:0]      beat_cnt_reg;

    // Captured configuration
    logic [DIM_W-1:0]      hsize_reg;
    logic [PITCH_W-1:0]    src_pitch_reg, dst_pitch_reg;

    // Read side
    logic                  arvalid_reg;
    logic [ADDR_W-1:0]     araddr_reg;
    logic [DIM_W-1:0]      ar_col_reg;
    logic [ADDR_W-1:0]     src_row_reg;
    logic [TOT_W-1:0]      ar_left_reg;
    logic [CNT_W-1:0]      rd_out_reg;

    // Read-data FIFO
    logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      fifo_cnt_reg;

    // Write side
    logic                  awvalid_reg, wvalid_reg;
    logic [ADDR_W-1:0]     awaddr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DIM_W-1:0]      aw_col_reg;
    logic [ADDR_W-1:0]     dst_row_reg;
    logic [WO_W-1:0]       wr_out_reg;

    logic run, ar_fire, r_fire, aw_fire, w_fire, b_fire;
    logic credit_ok, ar_issue, fifo_push, fifo_pop, copy_idle;
    logic ar_last_col, aw_last_col;
    logic [TOT_W-1:0] total_beats;

    assign run     = (state_reg == RUN);
    assign ar_fire = arvalid_reg && m_arready;
    assign aw_fire = awvalid_reg && m_awready;
    assign w_fire  = wvalid_reg && m_wready;
    assign r_fire  = m_rvalid && busy_reg;
    assign b_fire  = m_bvalid && busy_reg;

    assign total_beats = TOT_W'(cfg_hsize) * TOT_W'(cfg_vsize);

    // A read counts against the FIFO from the cycle its AR is raised, so
    // buffered data plus reads in flight can never exceed the FIFO size.
    assign credit_ok = ({1'b0, fifo_cnt_reg} + {1'b0, rd_out_reg}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign ar_issue  = run && (ar_left_reg != '0) && (!arvalid_reg || m_arready) && credit_ok;

    assign fifo_push = r_fire;
    assign fifo_pop  = run && (fifo_cnt_reg != '0) && !awvalid_reg && !wvalid_reg
                       && (wr_out_reg < WO_W'(MAX_WR_OUT));

    assign copy_idle = (ar_left_reg == '0) && (rd_out_reg == '0) && (fifo_cnt_reg == '0)
                       && !awvalid_reg && !wvalid_reg && (wr_out_reg == '0);

    assign ar_last_col = (ar_col_reg == hsize_reg - DIM_W'(1));
    assign aw_last_col = (aw_col_reg == hsize_reg - DIM_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            beat_cnt_reg  <= '0;
            hsize_reg     <= '0;
            src_pitch_reg <= '0;
            dst_pitch_reg <= '0;
            arvalid_reg   <= 1'b0;
            araddr_reg    <= '0;
            ar_col_reg    <= '0;
            src_row_reg   <= '0;
            ar_left_reg   <= '0;
            rd_out_reg    <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fifo_cnt_reg  <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            awaddr_reg    <= '0;
            aw_col_reg    <= '0;
            dst_row_reg   <= '0;
            wr_out_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (cfg_start) begin
                        hsize_reg     <= cfg_hsize;
                        src_pitch_reg <= cfg_src_pitch;
                        dst_pitch_reg <= cfg_dst_pitch;
                        src_row_reg   <= cfg_src_baddr;
                        dst_row_reg   <= cfg_dst_baddr;
                        ar_col_reg    <= '0;
                        aw_col_reg    <= '0;
                        ar_left_reg   <= total_beats;
                        err_reg       <= 1'b0;
                        beat_cnt_reg  <= '0;
                        if (total_beats == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (copy_idle) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
            endcase

            // AR channel: the address only changes when a new read is raised,
            // which is never while an unaccepted AR is still on the bus.
            if (ar_issue) begin
                arvalid_reg <= 1'b1;
                araddr_reg  <= src_row_reg + (ADDR_W'(ar_col_reg) << OFF_SH);
                ar_left_reg <= ar_left_reg - TOT_W'(1);
                if (ar_last_col) begin
                    ar_col_reg  <= '0;
                    src_row_reg <= src_row_reg + ADDR_W'(src_pitch_reg);
                end else begin
                    ar_col_reg  <= ar_col_reg + DIM_W'(1);
                end
            end else if (ar_fire) begin
                arvalid_reg <= 1'b0;
            end
            rd_out_reg <= rd_out_reg + CNT_W'(ar_issue) - CNT_W'(r_fire);

            // FIFO bookkeeping
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

            // AW/W pair: both raised together after a pop, each dropped on its
            // own handshake; the next pop waits until both are gone.
            if (fifo_pop) begin
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
                awaddr_reg  <= dst_row_reg + (ADDR_W'(aw_col_reg) << OFF_SH);
                if (aw_last_col) begin
                    aw_col_reg  <= '0;
                    dst_row_reg <= dst_row_reg + ADDR_W'(dst_pitch_reg);
                end else begin
                    aw_col_reg  <= aw_col_reg + DIM_W'(1);
                end
            end else begin
                if (aw_fire) awvalid_reg <= 1'b0;
                if (w_fire)  wvalid_reg  <= 1'b0;
            end
            wr_out_reg <= wr_out_reg + WO_W'(fifo_pop) - WO_W'(b_fire);

            if (b_fire) beat_cnt_reg <= beat_cnt_reg + TOT_W'(1);
            if ((r_fire && m_rresp != 2'b00) || (b_fire && m_bresp != 2'b00))
                err_reg <= 1'b1;
        end
    end

    // FIFO storage with registered read into the write-data register.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_reg] <= m_rdata;
        if (fifo_pop)  wdata_reg <= fifo_mem[rd_ptr_reg];
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && !fifo_pop && fifo_cnt_reg == CNT_W'(FIFO_DEPTH)));

    assign m_awvalid = awvalid_reg;
    assign m_awaddr  = awaddr_reg;
    assign m_awprot  = 3'b000;
    assign m_wvalid  = wvalid_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = '1;
    assign m_bready  = busy_reg;
    assign m_arvalid = arvalid_reg;
    assign m_araddr  = araddr_reg;
    assign m_arprot  = 3'b000;
    assign m_rready  = busy_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign beat_cnt  = beat_cnt_reg;
endmodule

// File: tb/tb_axil_win_copy.sv
// Testbench for axil_win_copy: a randomised AXI4-lite slave model plus a
// scoreboard fed by a window-level reference model of the expected traffic.
module tb_axil_win_copy;
    localparam int AW = 32, DW = 32, DIMW = 8, PW = 12, FD = 4, MWO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0] m_awprot, m_arprot;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW/8-1:0] m_wstrb;
    logic [1:0] m_bresp, m_rresp;
    logic [DIMW-1:0] cfg_hsize, cfg_vsize;
    logic [AW-1:0] cfg_src_baddr, cfg_dst_baddr;
    logic [PW-1:0] cfg_src_pitch, cfg_dst_pitch;
    logic cfg_start, busy, done, err;
    logic [2*DIMW-1:0] beat_cnt;

    axil_win_copy #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(DIMW), .PITCH_W(PW),
                    .FIFO_DEPTH(FD), .MAX_WR_OUT(MWO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .cfg_hsize(cfg_hsize), .cfg_vsize(cfg_vsize),
        .cfg_src_baddr(cfg_src_baddr), .cfg_dst_baddr(cfg_dst_baddr),
        .cfg_src_pitch(cfg_src_pitch), .cfg_dst_pitch(cfg_dst_pitch),
        .cfg_start(cfg_start), .busy(busy), .done(done), .err(err), .beat_cnt(beat_cnt)
    );

    int n_checks = 0, n_errors = 0;

    // Slave knobs
    int ar_pct = 100, aw_pct = 100, w_pct = 100, b_delay = 0;
    int r_err_idx = -1, b_err_idx = -1;
    int slv_r_idx = 0, slv_b_idx = 0;
    bit r_hold = 0, flush = 0;
    logic [31:0] seed = 32'h1234_5678;

    // Scoreboard
    logic [31:0] exp_ar[$], exp_aw[$], exp_w[$];
    int done_cnt = 0, ar_fire_cnt = 0, base_done = 0, base_ar = 0, total = 0;
    bit valid_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Contents of the slave memory: a fixed function of the address.
    function automatic logic [31:0] src_word(input logic [31:0] a, input logic [31:0] s);
        return {a[15:0], a[31:16]} ^ s ^ 32'h5A5A_C3C3;
    endfunction

    // Slave model: samples handshakes of the previous posedge, drives at negedge.
    initial begin : slave
        logic [31:0] rq[$];
        longint bq[$];
        longint cyc;
        int aw_n, w_n;
        bit s_arv, s_arr, s_rv, s_rr, s_awv, s_awr, s_wv, s_wr, s_bv, s_br;
        logic [31:0] s_araddr;
        cyc = 0; aw_n = 0; w_n = 0;
        {s_arv, s_arr, s_rv, s_rr, s_awv, s_awr, s_wv, s_wr, s_bv, s_br} = '0;
        s_araddr = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (flush) begin
                rq.delete(); bq.delete(); aw_n = 0; w_n = 0;
                m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
                {s_arv, s_arr, s_rv, s_rr, s_awv, s_awr, s_wv, s_wr, s_bv, s_br} = '0;
                continue;
            end
            if (s_rv && s_rr) begin void'(rq.pop_front()); slv_r_idx++; end
            if (s_arv && s_arr) rq.push_back(s_araddr);
            if (s_awv && s_awr) aw_n++;
            if (s_wv && s_wr) w_n++;
            while (aw_n > 0 && w_n > 0) begin
                bq.push_back(cyc + longint'(b_delay));
                aw_n--; w_n--;
            end
            if (s_bv && s_br) begin void'(bq.pop_front()); slv_b_idx++; end

            m_arready = (int'($urandom_range(99)) < ar_pct);
            m_rvalid  = !r_hold && (rq.size() > 0);
            m_rdata   = (rq.size() > 0) ? src_word(rq[0], seed) : 32'h0;
            m_rresp   = (slv_r_idx == r_err_idx) ? 2'b10 : 2'b00;
            m_awready = (int'($urandom_range(99)) < aw_pct);
            m_wready  = (int'($urandom_range(99)) < w_pct);
            m_bvalid  = (bq.size() > 0) && (bq[0] <= cyc);
            m_bresp   = (slv_b_idx == b_err_idx) ? 2'b11 : 2'b00;

            s_arv = m_arvalid; s_arr = m_arready; s_araddr = m_araddr;
            s_rv = m_rvalid; s_rr = m_rready;
            s_awv = m_awvalid; s_awr = m_awready;
            s_wv = m_wvalid; s_wr = m_wready;
            s_bv = m_bvalid; s_br = m_bready;
        end
    end

    // Monitor: pops the expected queues whenever a handshake is observed.
    initial begin : monitor
        bit p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [1:0] p_rresp, p_bresp;
        int rd_infl, wr_unack;
        rd_infl = 0; wr_unack = 0;
        {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_rresp = '0; p_bresp = '0;
        forever begin
            @(negedge clk);
            #1;
            if (flush) begin
                exp_ar.delete(); exp_aw.delete(); exp_w.delete();
                rd_infl = 0; wr_unack = 0;
                {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
                continue;
            end
            if (done) done_cnt++;
            if (m_arvalid || m_awvalid || m_wvalid) valid_seen = 1;
            if (p_rv && p_rr) begin
                rd_infl--;
                if (p_rresp != 2'b00) check("err_after_rresp", err, 1);
            end
            if (p_arv && p_arr) begin
                ar_fire_cnt++;
                rd_infl++;
                if (exp_ar.size() == 0) check("araddr_unexpected", p_araddr, 64'hFFFF_FFFF_FFFF);
                else check("araddr", p_araddr, exp_ar.pop_front());
                check("reads_outstanding_le_depth", rd_infl <= FD, 1);
            end
            if (p_bv && p_br) begin
                wr_unack--;
                if (p_bresp != 2'b00) check("err_after_bresp", err, 1);
            end
            if (p_awv && p_awr) begin
                wr_unack++;
                if (exp_aw.size() == 0) check("awaddr_unexpected", p_awaddr, 64'hFFFF_FFFF_FFFF);
                else check("awaddr", p_awaddr, exp_aw.pop_front());
                check("writes_unacked_le_max", wr_unack <= MWO, 1);
            end
            if (p_wv && p_wr) begin
                if (exp_w.size() == 0) check("wdata_unexpected", p_wdata, 64'hFFFF_FFFF_FFFF);
                else check("wdata", p_wdata, exp_w.pop_front());
            end
            p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
            p_rv = m_rvalid; p_rr = m_rready; p_rresp = m_rresp;
            p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
            p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata;
            p_bv = m_bvalid; p_br = m_bready; p_bresp = m_bresp;
        end
    end

    // Reference model: the window walked row by row, column by column.
    task automatic start_copy(input int h, input int v, input logic [31:0] src,
                              input logic [31:0] dst, input int sp, input int dp);
        logic [31:0] sa, da;
        total = h * v;
        for (int r = 0; r < v; r++) begin
            for (int c = 0; c < h; c++) begin
                sa = src + 32'(r * sp) + 32'(c * 4);
                da = dst + 32'(r * dp) + 32'(c * 4);
                exp_ar.push_back(sa);
                exp_aw.push_back(da);
                exp_w.push_back(src_word(sa, seed));
            end
        end
        slv_r_idx = 0; slv_b_idx = 0;
        base_done = done_cnt; base_ar = ar_fire_cnt; valid_seen = 0;
        @(negedge clk); #2;
        cfg_hsize = DIMW'(h); cfg_vsize = DIMW'(v);
        cfg_src_baddr = src; cfg_dst_baddr = dst;
        cfg_src_pitch = PW'(sp); cfg_dst_pitch = PW'(dp);
        cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
        @(negedge clk); #2;
        if (total > 0) begin
            check("start_busy", busy, 1);
            check("start_err_cleared", err, 0);
            check("start_beat_cnt_cleared", beat_cnt, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #3;
        rst_n = 0; flush = 1;
        #1;
        check("reset_outputs_zero",
              {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, busy, done, err, beat_cnt, m_araddr, m_awaddr},
              0);
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1; flush = 0;
    endtask

    task automatic finish_copy(input bit exp_err, input int max_cyc, output int cyc);
        bit got;
        got = 0; cyc = max_cyc;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin got = 1; cyc = i; break; end
            @(negedge clk); #2;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("beat_cnt_at_done", beat_cnt, total);
            check("err_at_done", err, exp_err);
            check("busy_low_in_done", busy, 0);
        end
        repeat (3) @(negedge clk);
        #2;
        check("single_done_pulse", done_cnt - base_done, 1);
        check("ar_all_seen", exp_ar.size(), 0);
        check("aw_all_seen", exp_aw.size(), 0);
        check("w_all_seen", exp_w.size(), 0);
        if (!got) do_reset();
        $display("copy %0dx? total=%0d done_after=%0d cycles beat_cnt=%0d err=%0d",
                 cfg_hsize, total, cyc, beat_cnt, err);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, h, v, sp, dp;
        cfg_hsize = 0; cfg_vsize = 0; cfg_src_baddr = 0; cfg_dst_baddr = 0;
        cfg_src_pitch = 0; cfg_dst_pitch = 0; cfg_start = 0;
        repeat (2) @(negedge clk);
        #2;
        check("reset_state",
              {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, busy, done, err, beat_cnt, m_araddr, m_awaddr},
              0);
        check("wstrb_all_ones", m_wstrb, 4'hF);
        rst_n = 1;

        // Basic copy, zero-wait slave
        start_copy(4, 3, 32'h1000, 32'h2000, 32'h40, 32'h40);
        finish_copy(0, 500, cyc);

        // Read data withheld: only FIFO_DEPTH reads may be outstanding
        r_hold = 1;
        start_copy(4, 3, 32'h3000, 32'h4000, 32'h40, 32'h80);
        repeat (19) @(negedge clk);
        #2;
        check("rhold_ar_count", ar_fire_cnt - base_ar, FD);
        check("rhold_arvalid_low", m_arvalid, 0);
        r_hold = 0;
        finish_copy(0, 500, cyc);

        // Random AW/W readiness, slow B
        aw_pct = 50; w_pct = 40; b_delay = 10;
        start_copy(5, 4, 32'h5000, 32'h6000, 32'h20, 32'h30);
        finish_copy(0, 3000, cyc);
        aw_pct = 100; w_pct = 100; b_delay = 0;

        // Response errors do not stop the copy
        seed = 32'hCAFE_0001;
        r_err_idx = 5; b_err_idx = 9;
        start_copy(4, 3, 32'h1000, 32'h2000, 32'h40, 32'h40);
        finish_copy(1, 500, cyc);
        r_err_idx = -1; b_err_idx = -1;

        // Next start clears err (checked inside start_copy)
        start_copy(3, 2, 32'h7000, 32'h7800, 32'h10, 32'h10);
        finish_copy(0, 500, cyc);

        // Zero-size window
        start_copy(0, 7, 32'h1000, 32'h2000, 32'h40, 32'h40);
        finish_copy(0, 10, cyc);
        check("zero_done_within_2", cyc <= 1, 1);
        check("zero_no_valid", valid_seen, 0);

        // Start re-pulsed with different config mid-copy is ignored
        start_copy(5, 4, 32'h8000, 32'h9000, 32'h40, 32'h40);
        repeat (6) @(negedge clk);
        #2;
        cfg_start = 1; cfg_hsize = 1; cfg_src_baddr = 32'hDEAD_0000; cfg_dst_pitch = 12'h4;
        @(posedge clk); #1;
        cfg_start = 0;
        finish_copy(0, 500, cyc);

        // Reset in the middle of a copy
        start_copy(4, 3, 32'h1000, 32'h2000, 32'h40, 32'h40);
        repeat (5) @(negedge clk);
        do_reset();
        repeat (2) @(negedge clk);
        #2;
        check("post_reset_idle", {busy, m_arvalid, m_awvalid}, 0);

        // Address wrap
        start_copy(4, 2, 32'hFFFF_FFF8, 32'hFFFF_FFF0, 32'h100, 32'h100);
        finish_copy(0, 500, cyc);

        // Randomised windows and handshakes
        for (int t = 0; t < 5; t++) begin
            h = int'($urandom_range(1, 6));
            v = int'($urandom_range(1, 5));
            sp = h * 4 + 4 * int'($urandom_range(0, 8));
            dp = h * 4 + 4 * int'($urandom_range(0, 8));
            ar_pct = int'($urandom_range(30, 100));
            aw_pct = int'($urandom_range(30, 100));
            w_pct = int'($urandom_range(30, 100));
            b_delay = int'($urandom_range(0, 5));
            seed = $urandom;
            start_copy(h, v, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, sp, dp);
            finish_copy(0, 4000, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
